// File: rtl/calc_feeder.sv
// Operand-triple FIFO feeding three independent calc channels (A/B/C).
// Define CALC_FEEDER_LOCKSTEP_EN to make all three channels transfer together.
module calc_feeder #(
   parameter int DEPTH = 4,
   parameter int W     = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         pushIn,
   output logic         stopIn,
   input  logic [W-1:0] inA,
   input  logic [W-1:0] inB,
   input  logic [W-1:0] inC,
   output logic [W-1:0] A,
   output logic [W-1:0] B,
   output logic [W-1:0] C,
   output logic         pushA,
   output logic         pushB,
   output logic         pushC,
   input  logic         stopA,
   input  logic         stopB,
   input  logic         stopC,
   output logic [15:0]  tcount
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;

   logic [W-1:0]  r_mem_a [DEPTH];
   logic [W-1:0]  r_mem_b [DEPTH];
   logic [W-1:0]  r_mem_c [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [CW-1:0] r_count;
   logic          r_sent_a;
   logic          r_sent_b;
   logic          r_sent_c;
   logic [15:0]   r_tcount;

   logic w_empty;
   logic w_full;
   logic w_accept;
   logic w_retire;
   logic w_xfer_a;
   logic w_xfer_b;
   logic w_xfer_c;

   assign w_empty  = (r_count == '0);
   assign w_full   = (r_count == CW'(DEPTH));
   assign w_accept = pushIn & ~w_full;
   assign stopIn   = w_full;
   assign tcount   = r_tcount;

   assign A = w_empty ? '0 : r_mem_a[r_rptr];
   assign B = w_empty ? '0 : r_mem_b[r_rptr];
   assign C = w_empty ? '0 : r_mem_c[r_rptr];

`ifdef CALC_FEEDER_LOCKSTEP_EN
   logic w_go;
   assign w_go  = ~w_empty & ~stopA & ~stopB & ~stopC;
   assign pushA = w_go;
   assign pushB = w_go;
   assign pushC = w_go;
`else
   assign pushA = ~w_empty & ~r_sent_a;
   assign pushB = ~w_empty & ~r_sent_b;
   assign pushC = ~w_empty & ~r_sent_c;
`endif

   assign w_xfer_a = pushA & ~stopA;
   assign w_xfer_b = pushB & ~stopB;
   assign w_xfer_c = pushC & ~stopC;

   // Head retires once every channel has delivered, now or earlier.
   assign w_retire = ~w_empty
                   & (r_sent_a | w_xfer_a)
                   & (r_sent_b | w_xfer_b)
                   & (r_sent_c | w_xfer_c);

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_mem_a[r_wptr] <= inA;
         r_mem_b[r_wptr] <= inB;
         r_mem_c[r_wptr] <= inC;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wptr   <= '0;
         r_rptr   <= '0;
         r_count  <= '0;
         r_tcount <= '0;
      end else begin
         if (w_accept) begin
            r_wptr <= r_wptr + AW'(1);
         end
         if (w_retire) begin
            r_rptr   <= r_rptr + AW'(1);
            r_tcount <= r_tcount + 16'd1;
         end
         if (w_accept && !w_retire) begin
            r_count <= r_count + CW'(1);
         end else if (!w_accept && w_retire) begin
            r_count <= r_count - CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_sent_a <= 1'b0;
         r_sent_b <= 1'b0;
         r_sent_c <= 1'b0;
      end else begin
`ifdef CALC_FEEDER_LOCKSTEP_EN
         r_sent_a <= 1'b0;
         r_sent_b <= 1'b0;
         r_sent_c <= 1'b0;
`else
         if (w_retire) begin
            r_sent_a <= 1'b0;
            r_sent_b <= 1'b0;
            r_sent_c <= 1'b0;
         end else begin
            r_sent_a <= r_sent_a | w_xfer_a;
            r_sent_b <= r_sent_b | w_xfer_b;
            r_sent_c <= r_sent_c | w_xfer_c;
         end
`endif
      end
   end

endmodule

// File: tb/tb_calc_feeder.sv
// Scoreboard bench for calc_feeder: directed triples queued per channel,
// a negedge monitor pops and compares on every channel transfer.
module tb_calc_feeder;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         pushIn;
   logic         stopIn;
   logic [W-1:0] inA, inB, inC;
   logic [W-1:0] A, B, C;
   logic         pushA, pushB, pushC;
   logic         stopA, stopB, stopC;
   logic [15:0]  tcount;

   int n_vec = 0;
   int n_err = 0;

   logic [W-1:0] qa[$];
   logic [W-1:0] qb[$];
   logic [W-1:0] qc[$];

   calc_feeder #(.DEPTH(4), .W(W)) dut (
      .clk(clk), .rst(rst),
      .pushIn(pushIn), .stopIn(stopIn),
      .inA(inA), .inB(inB), .inC(inC),
      .A(A), .B(B), .C(C),
      .pushA(pushA), .pushB(pushB), .pushC(pushC),
      .stopA(stopA), .stopB(stopB), .stopC(stopC),
      .tcount(tcount)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [W-1:0] act,
                      input logic [W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic pop_chk(input string name, input logic [W-1:0] act,
                          inout logic [W-1:0] q[$]);
      logic [W-1:0] e;
      if (q.size() == 0) begin
         n_vec++;
         n_err++;
         $display("FAIL %s: unexpected transfer of %0h, expected none", name, act);
      end else begin
         e = q.pop_front();
         chk(name, act, e);
      end
   endtask

   // Transfers happen at the next posedge; inputs are stable from here.
   always @(negedge clk) begin
      if (rst === 1'b1) begin
         if (pushA && !stopA) pop_chk("chanA", A, qa);
         if (pushB && !stopB) pop_chk("chanB", B, qb);
         if (pushC && !stopC) pop_chk("chanC", C, qc);
`ifdef CALC_FEEDER_LOCKSTEP_EN
         chk("lockstep_ab", W'(pushA), W'(pushB));
         chk("lockstep_ac", W'(pushA), W'(pushC));
`endif
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      pushIn = 1'b0;
      tick();
      tick();
      qa.delete();
      qb.delete();
      qc.delete();
      rst = 1'b1;
   endtask

   // Offer one triple for one cycle; exp_stop is the bench's own expectation.
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] c, input logic exp_stop);
      pushIn = 1'b1;
      inA = a;
      inB = b;
      inC = c;
      @(negedge clk);
      chk("stopIn_at_push", W'(stopIn), W'(exp_stop));
      if (!exp_stop) begin
         qa.push_back(a);
         qb.push_back(b);
         qc.push_back(c);
      end
      tick();
      pushIn = 1'b0;
   endtask

   task automatic chk_push(input string name, input logic ea,
                           input logic eb, input logic ec);
      chk({name, "_pushA"}, W'(pushA), W'(ea));
      chk({name, "_pushB"}, W'(pushB), W'(eb));
      chk({name, "_pushC"}, W'(pushC), W'(ec));
   endtask

   task automatic chk_drained(input string name);
      chk({name, "_qa_left"}, W'(qa.size()), '0);
      chk({name, "_qb_left"}, W'(qb.size()), '0);
      chk({name, "_qc_left"}, W'(qc.size()), '0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      stopA = 1'b0; stopB = 1'b0; stopC = 1'b0;
      inA = '0; inB = '0; inC = '0;
      do_reset();
      rst = 1'b0;
      @(negedge clk);
      chk_push("reset", 1'b0, 1'b0, 1'b0);
      chk("reset_A", A, '0);
      chk("reset_B", B, '0);
      chk("reset_C", C, '0);
      chk("reset_stopIn", W'(stopIn), '0);
      chk("reset_tcount", W'(tcount), '0);
      tick();
      rst = 1'b1;

      // Basic latency: offered the cycle after accept, retired one edge later.
      send(32'd5, -32'sd7, 32'd300, 1'b0);
      @(negedge clk);
      chk_push("lat", 1'b1, 1'b1, 1'b1);
      chk("lat_A", A, 32'd5);
      chk("lat_B", B, 32'hFFFF_FFF9);
      chk("lat_C", C, 32'd300);
      tick();
      chk("lat_tcount", W'(tcount), 32'd1);
      chk("lat_empty_A", A, '0);
      chk_drained("lat");

      // Fill under backpressure, reject a 5th, then drain at full rate.
      do_reset();
      stopA = 1'b1; stopB = 1'b1; stopC = 1'b1;
      for (int i = 0; i < 4; i++) send(W'(10 + i), W'(20 + i), W'(30 + i), 1'b0);
      chk("fill_stopIn", W'(stopIn), 32'd1);
      send(32'd99, 32'd98, 32'd97, 1'b1);
      chk("fill_tcount", W'(tcount), '0);
      stopA = 1'b0; stopB = 1'b0; stopC = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      chk("fill_tcount_drain", W'(tcount), 32'd4);
      chk("fill_stopIn_drain", W'(stopIn), '0);
      chk_drained("fill");

`ifndef CALC_FEEDER_LOCKSTEP_EN
      // B held off three cycles while A and C go once.
      do_reset();
      stopB = 1'b1;
      send(32'd11, 32'd22, 32'd33, 1'b0);
      @(negedge clk);
      chk_push("stall1", 1'b1, 1'b1, 1'b1);
      tick();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk_push("stallB", 1'b0, 1'b1, 1'b0);
         chk("stallB_data", B, 32'd22);
         tick();
      end
      chk("stallB_tcount", W'(tcount), '0);
      stopB = 1'b0;
      @(negedge clk);
      chk_push("releaseB", 1'b0, 1'b1, 1'b0);
      tick();
      chk("releaseB_tcount", W'(tcount), 32'd1);
      @(negedge clk);
      chk_push("releaseB_idle", 1'b0, 1'b0, 1'b0);
      tick();
      chk_drained("stallB");
`endif

      // Full FIFO: push during retire edge is rejected, accepted next cycle.
      do_reset();
      stopA = 1'b1; stopB = 1'b1; stopC = 1'b1;
      for (int i = 0; i < 4; i++) send(W'(40 + i), W'(50 + i), W'(60 + i), 1'b0);
      stopA = 1'b0; stopB = 1'b0; stopC = 1'b0;
      send(32'd77, 32'd78, 32'd79, 1'b1);
      send(32'd77, 32'd78, 32'd79, 1'b0);
      for (int i = 0; i < 4; i++) tick();
      chk("fullret_tcount", W'(tcount), 32'd5);
      chk_drained("fullret");

      // Reset mid-stream with A of the head already sent.
      do_reset();
      stopB = 1'b1; stopC = 1'b1;
      for (int i = 0; i < 3; i++) send(W'(70 + i), W'(80 + i), W'(90 + i), 1'b0);
      rst = 1'b0;
      tick();
      qa.delete();
      qb.delete();
      qc.delete();
      @(negedge clk);
      chk_push("midrst", 1'b0, 1'b0, 1'b0);
      chk("midrst_tcount", W'(tcount), '0);
      chk("midrst_stopIn", W'(stopIn), '0);
      tick();
      rst = 1'b1;
      stopB = 1'b0; stopC = 1'b0;
      @(negedge clk);
      chk_push("postrst", 1'b0, 1'b0, 1'b0);
      tick();
      send(32'd123, 32'd456, 32'd789, 1'b0);
      @(negedge clk);
      chk_push("postrst_new", 1'b1, 1'b1, 1'b1);
      tick();
      chk("postrst_tcount", W'(tcount), 32'd1);
      chk_drained("postrst");

`ifdef CALC_FEEDER_LOCKSTEP_EN
      // All channels wait on stopC, then go together.
      do_reset();
      stopC = 1'b1;
      send(32'd1, 32'd2, 32'd3, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk_push("lock_hold", 1'b0, 1'b0, 1'b0);
         tick();
      end
      stopC = 1'b0;
      @(negedge clk);
      chk_push("lock_go", 1'b1, 1'b1, 1'b1);
      tick();
      chk("lock_tcount", W'(tcount), 32'd1);
      chk_drained("lock");
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
